conv_acc_seq: RTL and testbench
===============================

# conv_acc_seq

Sequencer that drives one shared sign-magnitude `adder` instance (18-bit words at WIDTH=9, registered output, 1-cycle latency) to accumulate one convolution window of TAPS products into a single sum. Sits between the multiplier array's product stream and the next pipeline stage.
- Accepts products through a valid/ready handshake.
- Feeds the products and the adder's fed-back sum into the adder, one product per cycle.
- Presents the finished, zero-normalized window sum with its own valid/ready handshake.

## Interface
- WIDTH, 9, operand half-width; data words are 2*WIDTH bits, sign-magnitude: bit 2*WIDTH-1 is the sign, the low 2*WIDTH-1 bits are the magnitude.
- TAPS, 9, products per window; legal range 2..256.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  product available.
- in_ready  out  1  block accepts a product this cycle.
- in_data  in  2*WIDTH  product, sign-magnitude.
- add_a  out  2*WIDTH  adder operand a.
- add_b  out  2*WIDTH  adder operand b.
- add_sum  in  2*WIDTH  adder registered output.
- out_valid  out  1  window sum available.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  2*WIDTH  window sum, sign-magnitude, never negative zero.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: no window in progress.
  - ACC: accepting taps.
  - DRAIN: one cycle waiting for the adder result.
  - HOLD: result presented downstream.
- Tap counter `cnt`, width clog2(TAPS).
- A tap is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACC, 0 in DRAIN and HOLD.
- Adder drive (combinational):
  - Tap accepted with cnt==0: add_a=in_data, add_b=0.
  - Tap accepted with cnt>0: add_a=in_data, add_b=add_sum.
  - No tap accepted, in ACC, DRAIN or HOLD: add_a=0, add_b=add_sum. Adding +0 holds the running sum during stalls and clears a negative zero.
  - IDLE with no accept: add_a=0, add_b=0.
- IDLE:
  - Accept → cnt=1, go to ACC.
  - If TAPS would be reached on this accept, go to DRAIN instead. This path is unreachable because TAPS≥2.
- ACC:
  - Accept → cnt+1.
  - Accept when cnt==TAPS-1 → cnt=0, go to DRAIN.
  - No accept → remain in ACC, counter unchanged.
- DRAIN: out_data <= add_sum with the sign bit forced to 0 if the magnitude is 0; out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid=1; out_data held stable while out_ready=0.
  - out_valid && out_ready → out_valid <= 0, go to IDLE.
- Arithmetic:
  - The magnitude wraps mod 2^(2*WIDTH-1) inside the adder; there is no overflow detection or saturation.
  - For operands of opposite sign and equal magnitude, the adder returns 0 with the sign of a.
  - Final normalization in DRAIN removes negative zero.
- Reset (rst_n=0 at a rising edge, from any state):
  - state=IDLE, cnt=0.
  - out_valid=0, out_data=0, busy=0.
  - A partial window is discarded.
  - The adder does not update while rst_n=0; stale add_sum is harmless because the next first tap drives add_b=0.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, busy=0, add_a=0, add_b=0.
- Throughput: 1 tap per cycle when in_valid is continuous.
- Latency: last tap accepted at cycle t → add_sum valid at t+1 (DRAIN) → out_valid=1 and out_data valid from t+2.
- Minimum window period is TAPS+2 cycles. in_ready is low for 2 cycles plus any out_ready stall.
- in_valid gaps in ACC stretch the window with no loss or duplication of taps.
- out_ready may be high before out_valid; handshake completes in the first HOLD cycle, returning to IDLE at t+3.
- in_data is sampled only on accept; out_data changes only on the DRAIN→HOLD edge or on reset.

## Test plan
- Reset then 9 continuous taps of +1 (0x00001) → out_valid rises exactly 2 cycles after the 9th accept; out_data=0x00009; in_ready low during DRAIN and HOLD.
- Mixed signs, taps +100, −30, +5, −80, +2, +0, −7, +10, +1 → out_data = +1 (0x00001). Cross-check every tap against a signed reference model.
- Cancellation, taps +50, −50, then 7×0 with negative sign bit (0x20000) → out_data=0x00000, sign bit 0.
- Random in_valid gaps and 20-cycle out_ready backpressure, 4 back-to-back windows → sums match the model, out_data stable during the stall, no tap lost or duplicated.
- Assert rst_n=0 after the 5th tap, release, feed 9 taps of −2 → the first output is 0x20012 (−18) with no contribution from the aborted window; all outputs at reset values during reset.
- Wrap: 9 taps of magnitude 0x1FFFF, positive → out_data = (9×0x1FFFF) mod 2^17 = 0x1FFF7, sign 0; no flag raised.

Source files
------------

// File: rtl/conv_acc_seq.sv
// Window accumulator sequencer: streams TAPS sign-magnitude products through one shared
// registered adder and hands the zero-normalized window sum downstream.
module conv_acc_seq #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned TAPS  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_data,
  output logic [2*WIDTH-1:0]   add_a,
  output logic [2*WIDTH-1:0]   add_b,
  input  logic [2*WIDTH-1:0]   add_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TAPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDrain,
    StHold
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            accept;
  logic [DW-1:0]   sum_norm;

  assign in_ready = (state == StIdle) || (state == StAcc);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != StIdle);

  // Negative zero can survive the adder (equal-magnitude cancellation); clear it on output.
  always_comb begin
    sum_norm = add_sum;
    if (add_sum[DW-2:0] == '0) begin
      sum_norm[DW-1] = 1'b0;
    end
  end

  // Outside IDLE a stall adds +0 so the adder keeps recirculating the running sum.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (accept) begin
      add_a = in_data;
      add_b = (cnt == '0) ? '0 : add_sum;
    end else if (state != StIdle) begin
      add_b = add_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            if (TAPS <= 1) begin
              cnt   <= '0;
              state <= StDrain;
            end else begin
              cnt   <= CntW'(1);
              state <= StAcc;
            end
          end
        end
        StAcc: begin
          if (accept) begin
            if (cnt == LastCnt) begin
              cnt   <= '0;
              state <= StDrain;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        StDrain: begin
          out_data  <= sum_norm;
          out_valid <= 1'b1;
          state     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_acc_seq.sv
// Directed bench for conv_acc_seq with a behavioural sign-magnitude registered adder.
module tb_conv_acc_seq;

  localparam int WIDTH = 9;
  localparam int TAPS  = 9;
  localparam int DW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_sum = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] win [TAPS];
  int            run_sum;

  always #5 clk = ~clk;

  conv_acc_seq #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] sm_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-2:0] ma, mb;
    logic [DW-1:0] r;
    ma = a[DW-2:0];
    mb = b[DW-2:0];
    if (a[DW-1] == b[DW-1]) r = {a[DW-1], ma + mb};
    else if (ma >= mb)      r = {a[DW-1], ma - mb};
    else                    r = {b[DW-1], mb - ma};
    return r;
  endfunction

  function automatic int sm2int(input logic [DW-1:0] v);
    return v[DW-1] ? -int'(v[DW-2:0]) : int'(v[DW-2:0]);
  endfunction

  // Shared adder: registered, frozen while reset is asserted.
  always @(posedge clk) begin
    if (rst_n) add_sum <= sm_add(add_a, add_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_window(input bit gaps, input bit xchk);
    int wait_cnt;
    run_sum = 0;
    for (int i = 0; i < TAPS; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_data  = 18'h15555;
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = win[i];
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
        tick();
        wait_cnt++;
      end
      if (wait_cnt >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      run_sum += sm2int(win[i]);
      if (xchk) check($sformatf("tap%0d_run", i), 32'(sm2int(add_sum)), 32'(run_sum));
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Entered 1ns after the last accept edge (DRAIN cycle).
  task automatic finish_window(input logic [DW-1:0] exp, input int stall);
    logic [DW-1:0] held;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_data", 32'(out_data), 32'(exp));
    check("hold_ready", 32'(in_ready), 32'd0);
    held = out_data;
    for (int c = 0; c < stall; c++) begin
      out_ready = 1'b0;
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(held));
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_add_a"}, 32'(add_a), 32'd0);
    check({tag, "_add_b"}, 32'(add_b), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Nine +1 taps, out_ready already high before out_valid.
    win = '{default: 18'h00001};
    feed_window(1'b0, 1'b1);
    finish_window(18'h00009, 0);

    // Mixed signs, including an intermediate cancellation.
    win = '{18'h00064, 18'h2001E, 18'h00005, 18'h20050, 18'h00002,
            18'h00000, 18'h20007, 18'h0000A, 18'h00001};
    feed_window(1'b0, 1'b1);
    finish_window(18'h00001, 0);

    // +50 -50 leaves negative zero in the adder; output must be +0.
    win = '{18'h00032, 18'h20032, 18'h20000, 18'h20000, 18'h20000,
            18'h20000, 18'h20000, 18'h20000, 18'h20000};
    feed_window(1'b0, 1'b1);
    check("neg_zero_in_adder", 32'(add_sum), 32'h20000);
    finish_window(18'h00000, 0);

    // Four back-to-back windows with random gaps and 20-cycle backpressure.
    win = '{default: 18'h00001};
    feed_window(1'b1, 1'b1);
    finish_window(18'h00009, 20);
    win = '{18'h00064, 18'h2001E, 18'h00005, 18'h20050, 18'h00002,
            18'h00000, 18'h20007, 18'h0000A, 18'h00001};
    feed_window(1'b1, 1'b1);
    finish_window(18'h00001, 20);
    win = '{18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005,
            18'h00006, 18'h00007, 18'h00008, 18'h00009};
    feed_window(1'b1, 1'b1);
    finish_window(18'h0002D, 20);
    win = '{default: 18'h20002};
    feed_window(1'b1, 1'b1);
    finish_window(18'h20012, 20);

    // Abort a window after 5 taps with reset, then a clean window of -2.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 18'h00003;
      tick();
    end
    check("abort_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check_reset_vals("mid_rst");
    tick();
    check("mid_rst_adder_frozen", 32'(add_sum), 32'h0000F);
    rst_n = 1'b1;
    tick();
    win = '{default: 18'h20002};
    feed_window(1'b0, 1'b1);
    finish_window(18'h20012, 0);

    // Magnitude wrap: 9 * 0x1FFFF mod 2^17.
    win = '{default: 18'h1FFFF};
    feed_window(1'b0, 1'b0);
    finish_window(18'h1FFF7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
